// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter window controllers.
package perf_pkg;

  // Default counter / result width.
  localparam int DEFAULT_W = 32;

  // Request operation encoding carried on req_stop.
  localparam logic OP_START = 1'b0;
  localparam logic OP_STOP  = 1'b1;

  // Window controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } cwc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping modulo NREQ. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan requests starting at ptr and take the first one found.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      int cand;
      cand = (int'(ptr) + off) % NREQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/cycle_window_ctrl.sv
// Arbitrates measurement windows on the shared cycle counter: grants one
// owner at a time, pulses the counter's on/off controls, snapshots the
// counter and returns the elapsed count over a valid/ready response.
module cycle_window_ctrl
  import perf_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = DEFAULT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_stop,
  output logic [NREQ-1:0]         req_ready,
  output logic                    cnt_on,
  output logic                    cnt_off,
  input  logic [W-1:0]            cnt_value,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [W-1:0]            rsp_cycles,
  output logic                    rsp_err
);

  localparam int IW = $clog2(NREQ);

  cwc_state_t      state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [W-1:0]    start_snap;
  logic [IW-1:0]   rsp_id_q;
  logic [W-1:0]    rsp_cycles_q;
  logic            rsp_err_q;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic [IW-1:0]   next_ptr;
  logic            grant_stop;
  logic            owner_stop;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign next_ptr   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
  assign grant_stop = (req_stop[arb_idx] == OP_STOP);
  assign owner_stop = req_valid[owner] && (req_stop[owner] == OP_STOP);

  // Handshake and counter-control decode; cnt_off is forced while in reset
  // so a window left open by reset is always closed.
  always_comb begin
    req_ready = '0;
    cnt_on    = 1'b0;
    cnt_off   = 1'b0;
    if (!rst) begin
      cnt_off = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            req_ready = arb_grant;
            cnt_on    = !grant_stop;
          end
        end
        RUN: begin
          if (owner_stop) begin
            req_ready[owner] = 1'b1;
            cnt_off          = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Response outputs are held at zero for every reset cycle.
  assign rsp_valid  = rst && (state == RESP);
  assign rsp_id     = rst ? rsp_id_q     : '0;
  assign rsp_cycles = rst ? rsp_cycles_q : '0;
  assign rsp_err    = rst ? rsp_err_q    : 1'b0;

  // Window FSM with snapshot, subtractor and response register.
  always_ff @(posedge clk) begin
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      start_snap   <= '0;
      rsp_id_q     <= '0;
      rsp_cycles_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            rr_ptr <= next_ptr;
            if (!grant_stop) begin
              start_snap <= cnt_value;
              owner      <= arb_idx;
              state      <= RUN;
            end else begin
              rsp_id_q     <= arb_idx;
              rsp_err_q    <= 1'b1;
              rsp_cycles_q <= '0;
              state        <= RESP;
            end
          end
        end
        RUN: begin
          if (owner_stop) state <= SETTLE;
        end
        SETTLE: begin
          // Modulo-2^W difference makes counter wrap harmless.
          rsp_cycles_q <= cnt_value - start_snap;
          rsp_id_q     <= owner;
          rsp_err_q    <= 1'b0;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cycle_window_ctrl.sv
// Self-checking bench for cycle_window_ctrl: a vector table, directed
// multi-cycle sequences, then random traffic against a transaction model.
module tb_cycle_window_ctrl;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_stop  = '0;
  logic [NREQ-1:0] req_ready;
  logic            cnt_on, cnt_off;
  logic [W-1:0]    cnt_value;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [0:0]      rsp_id;
  logic [W-1:0]    rsp_cycles;
  logic            rsp_err;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  cycle_window_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_stop   (req_stop),
    .req_ready  (req_ready),
    .cnt_on     (cnt_on),
    .cnt_off    (cnt_off),
    .cnt_value  (cnt_value),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_cycles (rsp_cycles),
    .rsp_err    (rsp_err)
  );

  // Free-running counter model controlled by cnt_on/cnt_off, with preset.
  logic [W-1:0] cnt = '0;
  logic         run = 1'b0;
  logic         preset_en = 1'b0;
  logic [W-1:0] preset_val = '0;
  assign cnt_value = cnt;

  always @(posedge clk) begin
    if (preset_en) cnt <= preset_val;
    else           cnt <= cnt + (run ? 32'd1 : 32'd0);
    if (cnt_off)     run <= 1'b0;
    else if (cnt_on) run <= 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] obs_all();
    return {25'd0, req_ready, cnt_on, cnt_off, rsp_valid, rsp_id, rsp_cycles, rsp_err};
  endfunction

  function automatic logic [63:0] obs_ctl();
    return {59'd0, req_ready, cnt_on, cnt_off, rsp_valid};
  endfunction

  function automatic logic [63:0] exp_all(input logic [1:0] er, input logic eon, eoff, ev,
                                          input logic eid, input logic [31:0] ec, input logic ee);
    return {25'd0, er, eon, eoff, ev, eid, ec, ee};
  endfunction

  function automatic logic [63:0] exp_ctl(input logic [1:0] er, input logic eon, eoff, ev);
    return {59'd0, er, eon, eoff, ev};
  endfunction

  // One clock cycle: drive inputs just after the edge, return mid-cycle.
  task automatic cycle(input logic r, input logic [1:0] v, input logic [1:0] s, input logic rr);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_stop  = s;
    rsp_ready = rr;
    preset_en = 1'b0;
    @(negedge clk);
  endtask

  // Full window for one requester: start, k-1 idle cycles, stop, settle, response.
  task automatic run_window(input int id, input int k, input logic [31:0] exp_cyc, input string tag);
    logic [1:0] m;
    m = 2'b01 << id;
    cycle(1'b1, m, 2'b00, 1'b1);
    check({tag, "_start"}, obs_ctl(), exp_ctl(m, 1'b1, 1'b0, 1'b0));
    repeat (k - 1) cycle(1'b1, 2'b00, 2'b00, 1'b1);
    cycle(1'b1, m, m, 1'b1);
    check({tag, "_stop"}, obs_ctl(), exp_ctl(m, 1'b0, 1'b1, 1'b0));
    cycle(1'b1, 2'b00, 2'b00, 1'b1);
    check({tag, "_settle"}, obs_ctl(), exp_ctl(2'b00, 1'b0, 1'b0, 1'b0));
    cycle(1'b1, 2'b00, 2'b00, 1'b1);
    check({tag, "_rsp"}, obs_all(), exp_all(2'b00, 1'b0, 1'b0, 1'b1, id[0], exp_cyc, 1'b0));
  endtask

  // Vector table record: inputs for one cycle and the outputs expected in it.
  typedef struct packed {
    logic        r;
    logic [1:0]  v;
    logic [1:0]  s;
    logic        rr;
    logic [1:0]  er;
    logic        eon;
    logic        eoff;
    logic        ev;
    logic        eid;
    logic [31:0] ec;
    logic        ee;
  } vec_t;

  // Transaction-level reference model state.
  int         m_rr, m_owner, m_start, m_k, cyc_no;
  bit         m_open, m_settle, m_resp;
  logic       m_id, m_err;
  logic [31:0] m_cyc;

  task automatic model_reset();
    m_rr = 0; m_owner = 0; m_start = 0; m_k = 0;
    m_open = 0; m_settle = 0; m_resp = 0;
    m_id = 1'b0; m_err = 1'b0; m_cyc = '0;
  endtask

  // Predict this cycle's outputs from the window rules, then advance.
  task automatic model_step(input logic [1:0] v, input logic [1:0] s, input logic rr,
                            output logic [63:0] e, output bit full);
    logic [1:0] er;
    logic eon, eoff, ev;
    int g;
    er = '0; eon = 0; eoff = 0; ev = 0; g = -1;
    if (m_resp) begin
      ev = 1;
      e = exp_all(er, eon, eoff, ev, m_id, m_cyc, m_err);
      if (rr) m_resp = 0;
    end else if (m_settle) begin
      e = exp_all(er, eon, eoff, ev, 1'b0, 32'd0, 1'b0);
      m_settle = 0; m_resp = 1;
      m_id = m_owner[0]; m_cyc = 32'(m_k); m_err = 0;
    end else if (m_open) begin
      if (v[m_owner] && s[m_owner]) begin
        er[m_owner] = 1; eoff = 1;
        m_k = cyc_no - m_start; m_open = 0; m_settle = 1;
      end
      e = exp_all(er, eon, eoff, ev, 1'b0, 32'd0, 1'b0);
    end else begin
      for (int off = 0; off < NREQ; off++)
        if (g < 0 && v[(m_rr + off) % NREQ]) g = (m_rr + off) % NREQ;
      if (g >= 0) begin
        er[g] = 1;
        m_rr = (g + 1) % NREQ;
        if (!s[g]) begin
          eon = 1; m_open = 1; m_owner = g; m_start = cyc_no;
        end else begin
          m_resp = 1; m_id = g[0]; m_err = 1; m_cyc = '0;
        end
      end
      e = exp_all(er, eon, eoff, ev, 1'b0, 32'd0, 1'b0);
    end
    full = ev;
    cyc_no++;
  endtask

  vec_t tv[18];

  initial begin
    logic [63:0] e;
    bit full;
    logic [1:0] rv, rs;
    logic rrdy;

    //            r  v      s      rr   er     on  off  v   id  cyc    err
    tv[0]  = '{1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0};
    tv[1]  = '{1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0};
    tv[2]  = '{1'b1, 2'b10, 2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    tv[3]  = '{1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b1};
    tv[4]  = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b1};
    tv[5]  = '{1'b1, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    tv[6]  = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    tv[7]  = '{1'b1, 2'b11, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0};
    tv[8]  = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    tv[9]  = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0};
    tv[10] = '{1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    tv[11] = '{1'b1, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    tv[12] = '{1'b1, 2'b11, 2'b11, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0};
    tv[13] = '{1'b1, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    tv[14] = '{1'b1, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'd2, 1'b0};
    tv[15] = '{1'b1, 2'b11, 2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    tv[16] = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1};
    tv[17] = '{1'b1, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};

    // Reset, error stop, contention, stop by non-owner, rr pointer.
    for (int i = 0; i < 18; i++) begin
      cycle(tv[i].r, tv[i].v, tv[i].s, tv[i].rr);
      if (tv[i].ev || !tv[i].r)
        check($sformatf("vec%0d", i), obs_all(),
              exp_all(tv[i].er, tv[i].eon, tv[i].eoff, tv[i].ev, tv[i].eid, tv[i].ec, tv[i].ee));
      else
        check($sformatf("vec%0d", i), obs_ctl(),
              exp_ctl(tv[i].er, tv[i].eon, tv[i].eoff, tv[i].ev));
    end

    // Basic window from counter value 100.
    cycle(1'b1, 2'b00, 2'b00, 1'b1);
    preset_en = 1'b1; preset_val = 32'd100;
    run_window(0, 10, 32'd10, "basic");

    // Window that crosses the counter wrap.
    cycle(1'b1, 2'b00, 2'b00, 1'b1);
    preset_en = 1'b1; preset_val = 32'hFFFF_FFFA;
    run_window(0, 12, 32'd12, "wrap");

    // Backpressure: response held 5 cycles while req0 waits to start.
    cycle(1'b1, 2'b10, 2'b00, 1'b1);
    check("bp_start", obs_ctl(), exp_ctl(2'b10, 1'b1, 1'b0, 1'b0));
    repeat (2) cycle(1'b1, 2'b00, 2'b00, 1'b1);
    cycle(1'b1, 2'b10, 2'b10, 1'b1);
    check("bp_stop", obs_ctl(), exp_ctl(2'b10, 1'b0, 1'b1, 1'b0));
    cycle(1'b1, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 2'b01, 2'b00, 1'b0);
      check($sformatf("bp_hold%0d", i), obs_all(), exp_all(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0));
    end
    cycle(1'b1, 2'b01, 2'b00, 1'b1);
    check("bp_handshake", obs_all(), exp_all(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0));
    cycle(1'b1, 2'b01, 2'b00, 1'b1);
    check("bp_idle_grant", obs_ctl(), exp_ctl(2'b01, 1'b1, 1'b0, 1'b0));

    // Reset for two cycles during req0's window.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 2'b11, 2'b11, 1'b1);
      check($sformatf("rst_mid%0d", i), obs_all(), exp_all(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));
    end
    run_window(1, 5, 32'd5, "fresh");

    // Random traffic against the reference model.
    cycle(1'b0, 2'b00, 2'b00, 1'b0);
    cycle(1'b0, 2'b00, 2'b00, 1'b0);
    model_reset();
    cyc_no = 0;
    for (int i = 0; i < 3000; i++) begin
      rv   = 2'($urandom_range(0, 3));
      rs   = 2'($urandom_range(0, 3));
      rrdy = ($urandom_range(0, 3) != 0);
      cycle(1'b1, rv, rs, rrdy);
      model_step(rv, rs, rrdy, e, full);
      if (full) check($sformatf("rand%0d", i), obs_all(), e);
      else      check($sformatf("rand%0d", i), obs_ctl(), {59'd0, e[38:34]});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
